// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone master.
//   wb_state_e     : master FSM state encoding
//   DefaultTimeout : default ack-wait limit in STROBE cycles
//   TimerWidth     : width of the ack-wait counter (covers 1..255)
package wb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStrobe,
        StGap
    } wb_state_e;

    localparam int unsigned DefaultTimeout = 255;
    localparam int unsigned TimerWidth     = 8;

endpackage

// File: rtl/parameters.sv
// Global bus-width macros shared by the Wishbone master slice.
//   `ADDR_WIDTH : default Wishbone address width
//   `DATA_WIDTH : default Wishbone data width
`ifndef WB_PARAMETERS_SV
`define WB_PARAMETERS_SV

`define ADDR_WIDTH 8
`define DATA_WIDTH 32

`endif

// File: rtl/wb_master_timer.sv
// Ack-wait timer for the Wishbone master.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   clear_i   : force the count to zero (held while not strobing)
//   enable_i  : count one stalled STROBE cycle
//   expired_o : TIMEOUT stalled cycles have been counted
module wb_master_timer
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [TimerWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + TimerWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TimerWidth'(TIMEOUT));

endmodule

// File: rtl/wb_master.sv
// Wishbone classic master: turns single writes and read bursts (1..16 beats)
// into Wishbone cycles with an ack timeout.
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o         : command handshake (ready only when idle)
//   cmd_we_i, cmd_adr_i, cmd_dat_i  : command kind, start address, write data
//   cmd_len_i                       : read beats minus one
//   rsp_valid_o, rsp_dat_o          : one pulse per beat, read data
//   rsp_last_o, rsp_err_o           : final beat, beat aborted
//   adr_o, dat_o, we_o, cyc_o, stb_o: Wishbone master outputs
//   dat_i, ack_i, err_i             : Wishbone slave responses
`ifndef WB_PARAMETERS_SV
`include "parameters.sv"
`endif

module wb_master
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned TIMEOUT    = DefaultTimeout
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [3:0]            cmd_len_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_last_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  we_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    input  logic                  ack_i,
    input  logic                  err_i
);

    wb_state_e             state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            beat_q, beat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                  rsp_last_q, rsp_last_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  timer_expired;
    logic                  last_beat;

    // Writes are always a single beat regardless of cmd_len_i.
    assign last_beat = we_q || (beat_q == len_q);

    // Counter is held clear outside STROBE, so every entry starts from zero.
    wb_master_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q != StStrobe),
        .enable_i  ((state_q == StStrobe) && !ack_i && !err_i),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        len_d       = len_q;
        beat_d      = beat_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = '0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    len_d   = cmd_len_i;
                    beat_d  = '0;
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                // err_i beats ack_i; a real ack on the expiry cycle still counts.
                if (err_i || (timer_expired && !ack_i)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = StIdle;
                end else if (ack_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : dat_i;
                    if (last_beat) begin
                        rsp_last_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        adr_d   = adr_q + ADDR_WIDTH'(1);
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                state_d = StStrobe;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign cyc_o       = (state_q != StIdle);
    assign stb_o       = (state_q == StStrobe);
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign we_o        = we_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: behavioural Wishbone slave, response scoreboard and
// directed scenarios (single read, write/readback, wrapping burst, timeout,
// err on a burst beat, reset mid-burst).
module tb_wb_master;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic [3:0]    cmd_len_i;
    logic          rsp_valid_o, rsp_last_o, rsp_err_o;
    logic [DW-1:0] rsp_dat_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o, dat_i;
    logic          we_o, cyc_o, stb_o, ack_i, err_i;

    always #5 clk = ~clk;

    wb_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_len_i   (cmd_len_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_last_o  (rsp_last_o),
        .rsp_err_o   (rsp_err_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .we_o        (we_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .ack_i       (ack_i),
        .err_i       (err_i)
    );

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
        logic          err;
    } rsp_t;

    rsp_t          rsp_q[$];
    logic [AW-1:0] adr_exp_q[$];
    int            n_vec  = 0;
    int            n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int unsigned a);
        return DW'(32'h5A00_0000 | (a << 8) | (a ^ 32'h3C));
    endfunction

    task automatic expect_rsp(input logic [DW-1:0] dat, input logic last, input logic err);
        rsp_t e;
        e.dat  = dat;
        e.last = last;
        e.err  = err;
        rsp_q.push_back(e);
    endtask

    // Behavioural slave: acks after wait_states stalled cycles, optional err beat.
    logic [DW-1:0] mem [256];
    int            wait_states = 0;
    int            stall_cnt   = 0;
    int            beat_no     = 0;
    int            err_beat    = -1;
    bit            never_ack   = 1'b0;

    always @(negedge clk) begin
        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = '0;
        if (stb_o && !rst_i) begin
            if (stall_cnt < wait_states) begin
                stall_cnt++;
            end else if (!never_ack) begin
                ack_i = 1'b1;
                if (beat_no == err_beat) err_i = 1'b1;
                if (we_o) mem[adr_o] = dat_o;
                dat_i = mem[adr_o];
                if (adr_exp_q.size() == 0) begin
                    check_eq("adr_unexpected", 64'(adr_o), 64'(1'b0) - 64'(1));
                end else begin
                    check_eq("adr_beat", 64'(adr_o), 64'(adr_exp_q.pop_front()));
                end
                beat_no++;
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
        if (!cyc_o) beat_no = 0;
    end

    // Response scoreboard and bus-shape monitor.
    int gap_len   = 0;
    int cyc_falls = 0;
    bit prev_cyc  = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid_o) begin
            if (rsp_q.size() == 0) begin
                check_eq("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check_eq("rsp_dat", 64'(rsp_dat_o), 64'(e.dat));
                check_eq("rsp_last", 64'(rsp_last_o), 64'(e.last));
                check_eq("rsp_err", 64'(rsp_err_o), 64'(e.err));
            end
        end
        if (cyc_o && !stb_o) begin
            gap_len++;
        end else if (stb_o) begin
            if (gap_len != 0) check_eq("gap_len", 64'(gap_len), 64'(1));
            gap_len = 0;
        end else begin
            gap_len = 0;
        end
        if (prev_cyc && !cyc_o) cyc_falls++;
        prev_cyc = cyc_o;
    end

    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [3:0] len);
        int budget = 0;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_len_i   = len;
        while (!cmd_ready_o && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready_o) check_eq("cmd_ready_wait", 64'(cmd_ready_o), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        check_eq("stb_after_accept", 64'({cyc_o, stb_o}), 64'(2'b11));
        check_eq("adr_after_accept", 64'(adr_o), 64'(adr));
        check_eq("we_after_accept", 64'(we_o), 64'(we));
        if (we) check_eq("dat_after_accept", 64'(dat_o), 64'(dat));
    endtask

    task automatic wait_done(input string tag);
        int b = 0;
        while ((rsp_q.size() != 0 || cyc_o) && b < 200) begin
            @(posedge clk);
            #2;
            b++;
        end
        check_eq({"done_", tag}, 64'({rsp_q.size() == 0, adr_exp_q.size() == 0, cyc_o}),
                 64'(3'b110));
        rsp_q.delete();
        adr_exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int busy;
        int stray;
        int falls0;
        for (int i = 0; i < 256; i++) mem[i] = pattern(i);
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_len_i   = '0;
        ack_i       = 1'b0;
        err_i       = 1'b0;
        dat_i       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_bus", 64'({cyc_o, stb_o, we_o}), 64'(0));
        check_eq("reset_adr_dat", 64'({adr_o, dat_o}), 64'(0));
        check_eq("reset_rsp", 64'({rsp_valid_o, rsp_last_o, rsp_err_o, rsp_dat_o}), 64'(0));
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_ready", 64'(cmd_ready_o), 64'(1));

        // Single read at 0x00.
        adr_exp_q.push_back(8'h00);
        expect_rsp(pattern(0), 1'b1, 1'b0);
        issue(1'b0, 8'h00, '0, 4'd0);
        wait_done("rd0");

        // Write then read back; cmd_len_i must be ignored for the write.
        adr_exp_q.push_back(8'h10);
        expect_rsp('0, 1'b1, 1'b0);
        issue(1'b1, 8'h10, 32'hDEAD_BEEF, 4'd5);
        wait_done("wr10");
        check_eq("mem_written", 64'(mem[8'h10]), 64'(32'hDEAD_BEEF));
        adr_exp_q.push_back(8'h10);
        expect_rsp(32'hDEAD_BEEF, 1'b1, 1'b0);
        issue(1'b0, 8'h10, '0, 4'd0);
        wait_done("rd10");

        // Four-beat burst wrapping through 0xFF -> 0x00, one wait state per beat.
        wait_states = 1;
        falls0      = cyc_falls;
        for (int i = 0; i < 4; i++) begin
            adr_exp_q.push_back(8'(8'hFE + i));
            expect_rsp(pattern((32'hFE + i) & 32'hFF), i == 3, 1'b0);
        end
        issue(1'b0, 8'hFE, '0, 4'd3);
        wait_done("burst_wrap");
        check_eq("burst_cyc_falls", 64'(cyc_falls - falls0), 64'(1));
        wait_states = 0;

        // Slave never acks: abort after TO stalled cycles.
        never_ack = 1'b1;
        expect_rsp('0, 1'b1, 1'b1);
        issue(1'b0, 8'h30, '0, 4'd2);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (cyc_o && n < 40);
        check_eq("timeout_cycles", 64'(n), 64'(TO + 1));
        never_ack = 1'b0;
        wait_done("timeout");
        check_eq("timeout_ready", 64'(cmd_ready_o), 64'(1));

        // err_i with ack_i on beat 2 of a 4-beat burst.
        err_beat = 1;
        adr_exp_q.push_back(8'h20);
        adr_exp_q.push_back(8'h21);
        expect_rsp(pattern(32'h20), 1'b0, 1'b0);
        expect_rsp('0, 1'b1, 1'b1);
        issue(1'b0, 8'h20, '0, 4'd3);
        wait_done("err_burst");
        err_beat = -1;
        busy = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (cyc_o || stb_o) busy++;
        end
        check_eq("err_bus_quiet", 64'(busy), 64'(0));

        // Reset during beat 3 of a burst.
        wait_states = 2;
        adr_exp_q.push_back(8'h40);
        adr_exp_q.push_back(8'h41);
        expect_rsp(pattern(32'h40), 1'b0, 1'b0);
        expect_rsp(pattern(32'h41), 1'b0, 1'b0);
        issue(1'b0, 8'h40, '0, 4'd3);
        n = 0;
        while (!(stb_o && beat_no == 2) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("beat3_reached", 64'(stb_o && beat_no == 2), 64'(1));
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_bus", 64'({cyc_o, stb_o}), 64'(0));
        rst_i       = 1'b0;
        wait_states = 0;
        stray       = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid_o) stray++;
        end
        check_eq("rst_no_rsp", 64'(stray), 64'(0));
        wait_done("rst_burst");
        adr_exp_q.push_back(8'h50);
        expect_rsp(pattern(32'h50), 1'b1, 1'b0);
        issue(1'b0, 8'h50, '0, 4'd0);
        wait_done("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wb_master.md
WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default `ADDR_WIDTH, width of adr_o and cmd_adr_i.
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH, width of all data buses.
REQ-003 Parameter TIMEOUT, default 255, max cycles stb_o waits for ack before abort; legal range 1..255.
REQ-004 Single clock, clk_i; reset rst_i, synchronous, active-high.
REQ-005 Ports (name direction width meaning) SHALL be:
  clk_i  in  1  clock
  rst_i  in  1  synchronous active-high reset
  cmd_valid_i  in  1  command request
  cmd_ready_o  out  1  master idle, command accepted when both high
  cmd_we_i  in  1  1=single write, 0=read burst
  cmd_adr_i  in  ADDR_WIDTH  start address
  cmd_dat_i  in  DATA_WIDTH  write data
  cmd_len_i  in  4  read beats minus 1 (0..15); ignored for writes
  rsp_valid_o  out  1  one-cycle response pulse per beat
  rsp_dat_o  out  DATA_WIDTH  read data (0 for writes and errors)
  rsp_last_o  out  1  final response of command
  rsp_err_o  out  1  beat terminated by timeout or err_i
  adr_o  out  ADDR_WIDTH  Wishbone address
  dat_o  out  DATA_WIDTH  Wishbone write data
  dat_i  in  DATA_WIDTH  Wishbone read data
  we_o  out  1  Wishbone write enable
  cyc_o  out  1  Wishbone cycle
  stb_o  out  1  Wishbone strobe
  ack_i  in  1  Wishbone acknowledge
  err_i  in  1  Wishbone error; tie 0 for slaves without it

Function
REQ-006 FSM states SHALL be IDLE, STROBE, GAP.
REQ-007 IDLE: cmd_ready_o=1, cyc_o=stb_o=0; on cmd_valid_i&&cmd_ready_o capture we/adr/dat/len, go STROBE; cyc_o, stb_o, adr_o, we_o, dat_o valid the following cycle.
REQ-008 STROBE: cyc_o=stb_o=1, cmd_ready_o=0; outputs held stable until ack_i, err_i or timeout.
REQ-009 ack_i sampled high in STROBE SHALL register dat_i (reads) and assert rsp_valid_o for exactly the next cycle.
REQ-010 Non-last read beat ack: go GAP for one cycle with stb_o=0, cyc_o=1, adr_o incremented by 1, then STROBE.
REQ-011 Last beat (beat count == cmd_len_i, or any write) ack: cyc_o=stb_o=0 next cycle, rsp_last_o=1 with that rsp_valid_o, go IDLE.
REQ-012 Address increment SHALL wrap modulo 2^ADDR_WIDTH (0xFF -> 0x00 at width 8).
REQ-013 Timeout counter SHALL clear on entry to STROBE and count each STROBE cycle without ack_i/err_i; at TIMEOUT cycles abort.
REQ-014 Abort (timeout or err_i sampled high in STROBE): cyc_o=stb_o=0 next cycle, one response with rsp_err_o=1, rsp_last_o=1, rsp_dat_o=0; remaining beats discarded; go IDLE.
REQ-015 ack_i and err_i high together: err_i SHALL win.
REQ-016 ack_i/err_i outside STROBE SHALL be ignored.
REQ-017 Write command: exactly one beat, rsp_valid_o with rsp_dat_o=0.
REQ-018 Back-to-back: new command accepted no earlier than the cycle rsp_last_o is high (cmd_ready_o=1 that cycle); at least one idle bus cycle between commands.
REQ-019 rsp_* has no backpressure; consumer SHALL accept every pulse.

Reset
REQ-020 At the edge where rst_i is sampled high: state=IDLE, cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, rsp_valid_o=rsp_last_o=rsp_err_o=0, rsp_dat_o=0, cmd_ready_o=1 after release, counters=0.
REQ-021 Reset mid-burst SHALL drop cyc_o/stb_o at that edge with no response issued.

Structure
REQ-022 State enum typedef and default TIMEOUT constant SHALL live in shared package wb_pkg; widths come from parameters.sv macros.
REQ-023 Timeout counter SHALL be sub-module wb_master_timer (clear, enable, expired output).

Verification
REQ-024 Single read addr 0x00 to wb_slave -> cyc_o/stb_o one cycle after accept, one rsp_valid_o, rsp_last_o=1, rsp_dat_o equals slave data, rsp_err_o=0.
REQ-025 Write 0xDEADBEEF to 0x10, then read 0x10 -> write rsp_dat_o=0; read rsp_dat_o=0xDEADBEEF.
REQ-026 Read burst cmd_len_i=3 at 0xFE -> adr_o sequence 0xFE,0xFF,0x00,0x01, stb_o low one cycle between beats, cyc_o continuous, 4 responses, rsp_last_o only on 4th.
REQ-027 Stub slave never acks, TIMEOUT=8 -> cyc_o falls 9 cycles after stb_o rises, one response rsp_err_o=1, rsp_last_o=1, cmd_ready_o=1 after.
REQ-028 err_i and ack_i together on beat 2 of 4-beat burst -> 2 responses, second with rsp_err_o=1, rsp_last_o=1; no further bus activity.
REQ-029 rst_i pulsed during beat 3 of a burst -> cyc_o=stb_o=0 at that edge, no rsp_valid_o, next command completes normally.
